// File: rtl/rename_mt.sv
// Register map table for a 2-wide rename stage: zero-latency source/old-dest lookup
// with intra-bundle and CDB bypass, plus dispatch, completion and recovery updates.
module rename_mt #(
    parameter int NUM_AR = 32,
    parameter int PR_W   = 7
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic [1:0]               id_dispatch_num,
    input  logic [$clog2(NUM_AR)-1:0] id_dest_idx0,
    input  logic [$clog2(NUM_AR)-1:0] id_dest_idx1,
    input  logic [$clog2(NUM_AR)-1:0] id_ra_idx0,
    input  logic [$clog2(NUM_AR)-1:0] id_rb_idx0,
    input  logic [$clog2(NUM_AR)-1:0] id_ra_idx1,
    input  logic [$clog2(NUM_AR)-1:0] id_rb_idx1,

    input  logic [PR_W-1:0]          fl_pr0,
    input  logic [PR_W-1:0]          fl_pr1,

    input  logic                     cdb_valid0,
    input  logic [PR_W-1:0]          cdb_tag0,
    input  logic                     cdb_valid1,
    input  logic [PR_W-1:0]          cdb_tag1,

    input  logic                     rob_recover,
    input  logic [NUM_AR*PR_W-1:0]   rrat_map_flat,

    output logic [PR_W-1:0]          mt_ra_tag0,
    output logic [PR_W-1:0]          mt_rb_tag0,
    output logic [PR_W-1:0]          mt_ra_tag1,
    output logic [PR_W-1:0]          mt_rb_tag1,
    output logic                     mt_ra_rdy0,
    output logic                     mt_rb_rdy0,
    output logic                     mt_ra_rdy1,
    output logic                     mt_rb_rdy1,
    output logic [PR_W-1:0]          mt_told0,
    output logic [PR_W-1:0]          mt_told1
);

    logic [PR_W-1:0]   map_tag_q [NUM_AR];
    logic [PR_W-1:0]   map_tag_d [NUM_AR];
    logic [NUM_AR-1:0] map_rdy_q;
    logic [NUM_AR-1:0] map_rdy_d;

    logic slot0_v;
    logic slot1_v;

    logic [PR_W-1:0] ra0_tag, rb0_tag, ra1_map_tag, rb1_map_tag;
    logic            ra0_rdy, rb0_rdy, ra1_map_rdy, rb1_map_rdy;
    logic            ra1_fwd, rb1_fwd, told1_fwd;

    function automatic logic cdb_hit(
        input logic [PR_W-1:0] tag,
        input logic            v0,
        input logic [PR_W-1:0] t0,
        input logic            v1,
        input logic [PR_W-1:0] t1
    );
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    // A dispatch count of 3 is not a legal bundle size and renames nothing.
    assign slot0_v = (id_dispatch_num == 2'd1) || (id_dispatch_num == 2'd2);
    assign slot1_v = (id_dispatch_num == 2'd2);

    always_comb begin
        ra0_tag     = map_tag_q[id_ra_idx0];
        rb0_tag     = map_tag_q[id_rb_idx0];
        ra1_map_tag = map_tag_q[id_ra_idx1];
        rb1_map_tag = map_tag_q[id_rb_idx1];

        ra0_rdy     = map_rdy_q[id_ra_idx0] |
                      cdb_hit(ra0_tag, cdb_valid0, cdb_tag0, cdb_valid1, cdb_tag1);
        rb0_rdy     = map_rdy_q[id_rb_idx0] |
                      cdb_hit(rb0_tag, cdb_valid0, cdb_tag0, cdb_valid1, cdb_tag1);
        ra1_map_rdy = map_rdy_q[id_ra_idx1] |
                      cdb_hit(ra1_map_tag, cdb_valid0, cdb_tag0, cdb_valid1, cdb_tag1);
        rb1_map_rdy = map_rdy_q[id_rb_idx1] |
                      cdb_hit(rb1_map_tag, cdb_valid0, cdb_tag0, cdb_valid1, cdb_tag1);

        ra1_fwd   = (id_ra_idx1 == id_dest_idx0);
        rb1_fwd   = (id_rb_idx1 == id_dest_idx0);
        told1_fwd = (id_dest_idx1 == id_dest_idx0);
    end

    // Slot 1 sees slot 0's fresh tag as not-ready; the CDB cannot have produced it yet.
    always_comb begin
        mt_ra_tag0 = '0;
        mt_rb_tag0 = '0;
        mt_ra_rdy0 = 1'b0;
        mt_rb_rdy0 = 1'b0;
        mt_told0   = '0;
        mt_ra_tag1 = '0;
        mt_rb_tag1 = '0;
        mt_ra_rdy1 = 1'b0;
        mt_rb_rdy1 = 1'b0;
        mt_told1   = '0;

        if (slot0_v) begin
            mt_ra_tag0 = ra0_tag;
            mt_rb_tag0 = rb0_tag;
            mt_ra_rdy0 = ra0_rdy;
            mt_rb_rdy0 = rb0_rdy;
            mt_told0   = map_tag_q[id_dest_idx0];
        end

        if (slot1_v) begin
            mt_ra_tag1 = ra1_fwd   ? fl_pr0 : ra1_map_tag;
            mt_ra_rdy1 = ra1_fwd   ? 1'b0   : ra1_map_rdy;
            mt_rb_tag1 = rb1_fwd   ? fl_pr0 : rb1_map_tag;
            mt_rb_rdy1 = rb1_fwd   ? 1'b0   : rb1_map_rdy;
            mt_told1   = told1_fwd ? fl_pr0 : map_tag_q[id_dest_idx1];
        end
    end

    // Completion marks old tags ready first; a rename of the same entry then overrides it.
    always_comb begin
        map_tag_d = map_tag_q;
        map_rdy_d = map_rdy_q;

        if (rob_recover) begin
            for (int i = 0; i < NUM_AR; i++) begin
                map_tag_d[i] = rrat_map_flat[i*PR_W +: PR_W];
                map_rdy_d[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_AR; i++) begin
                if (cdb_hit(map_tag_q[i], cdb_valid0, cdb_tag0, cdb_valid1, cdb_tag1)) begin
                    map_rdy_d[i] = 1'b1;
                end
            end
            if (slot0_v) begin
                map_tag_d[id_dest_idx0] = fl_pr0;
                map_rdy_d[id_dest_idx0] = 1'b0;
            end
            if (slot1_v) begin
                map_tag_d[id_dest_idx1] = fl_pr1;
                map_rdy_d[id_dest_idx1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_AR; i++) begin
                map_tag_q[i] <= PR_W'(i);
            end
            map_rdy_q <= '1;
        end else begin
            for (int i = 0; i < NUM_AR; i++) begin
                map_tag_q[i] <= map_tag_d[i];
            end
            map_rdy_q <= map_rdy_d;
        end
    end

endmodule

// File: tb/tb_rename_mt.sv
// Directed bench for rename_mt: a per-cycle map-table model plus hand-computed
// expectations for the reference scenarios.
module tb_rename_mt;

    logic        clock;
    logic        reset;
    logic [1:0]  dispatchNum;
    logic [4:0]  destIdx0, destIdx1, raIdx0, rbIdx0, raIdx1, rbIdx1;
    logic [6:0]  flPr0, flPr1;
    logic        cdbValid0, cdbValid1;
    logic [6:0]  cdbTag0, cdbTag1;
    logic        robRecover;
    logic [223:0] rratFlat;

    logic [6:0]  raTag0, rbTag0, raTag1, rbTag1, told0, told1;
    logic        raRdy0, rbRdy0, raRdy1, rbRdy1;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    logic [6:0] mTag [32];
    bit         mRdy [32];

    rename_mt dut (
        .clock(clock), .reset(reset),
        .id_dispatch_num(dispatchNum),
        .id_dest_idx0(destIdx0), .id_dest_idx1(destIdx1),
        .id_ra_idx0(raIdx0), .id_rb_idx0(rbIdx0),
        .id_ra_idx1(raIdx1), .id_rb_idx1(rbIdx1),
        .fl_pr0(flPr0), .fl_pr1(flPr1),
        .cdb_valid0(cdbValid0), .cdb_tag0(cdbTag0),
        .cdb_valid1(cdbValid1), .cdb_tag1(cdbTag1),
        .rob_recover(robRecover), .rrat_map_flat(rratFlat),
        .mt_ra_tag0(raTag0), .mt_rb_tag0(rbTag0),
        .mt_ra_tag1(raTag1), .mt_rb_tag1(rbTag1),
        .mt_ra_rdy0(raRdy0), .mt_rb_rdy0(rbRdy0),
        .mt_ra_rdy1(raRdy1), .mt_rb_rdy1(rbRdy1),
        .mt_told0(told0), .mt_told1(told1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cdbSees(input logic [6:0] t);
        return (cdbValid0 && cdbTag0 == t) || (cdbValid1 && cdbTag1 == t);
    endfunction

    function automatic int bundleSize();
        return (dispatchNum == 2'd3) ? 0 : int'(dispatchNum);
    endfunction

    task automatic modelSource(input int slot, input logic [4:0] src,
                               output logic [6:0] tag, output logic rdy);
        if (slot >= bundleSize()) begin
            tag = '0; rdy = 1'b0;
        end else if (slot == 1 && src == destIdx0) begin
            tag = flPr0; rdy = 1'b0;
        end else begin
            tag = mTag[src];
            rdy = mRdy[src] || cdbSees(mTag[src]);
        end
    endtask

    function automatic logic [6:0] modelTold(input int slot, input logic [4:0] dst);
        if (slot >= bundleSize()) return '0;
        if (slot == 1 && dst == destIdx0) return flPr0;
        return mTag[dst];
    endfunction

    // Reference map: reset to identity, recovery copies the retirement map,
    // otherwise completions first and then renames in slot order.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mTag[i] = 7'(i);
                mRdy[i] = 1'b1;
            end
        end else if (robRecover) begin
            for (int i = 0; i < 32; i++) begin
                mTag[i] = rratFlat[i*7 +: 7];
                mRdy[i] = 1'b1;
            end
        end else begin
            int n;
            n = bundleSize();
            for (int i = 0; i < 32; i++) begin
                if (cdbSees(mTag[i])) mRdy[i] = 1'b1;
            end
            if (n >= 1) begin mTag[destIdx0] = flPr0; mRdy[destIdx0] = 1'b0; end
            if (n >= 2) begin mTag[destIdx1] = flPr1; mRdy[destIdx1] = 1'b0; end
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            logic [6:0] t;
            logic       r;
            modelSource(0, raIdx0, t, r);
            checkOutput("model ra_tag0", 32'(raTag0), 32'(t));
            checkOutput("model ra_rdy0", 32'(raRdy0), 32'(r));
            modelSource(0, rbIdx0, t, r);
            checkOutput("model rb_tag0", 32'(rbTag0), 32'(t));
            checkOutput("model rb_rdy0", 32'(rbRdy0), 32'(r));
            modelSource(1, raIdx1, t, r);
            checkOutput("model ra_tag1", 32'(raTag1), 32'(t));
            checkOutput("model ra_rdy1", 32'(raRdy1), 32'(r));
            modelSource(1, rbIdx1, t, r);
            checkOutput("model rb_tag1", 32'(rbTag1), 32'(t));
            checkOutput("model rb_rdy1", 32'(rbRdy1), 32'(r));
            checkOutput("model told0", 32'(told0), 32'(modelTold(0, destIdx0)));
            checkOutput("model told1", 32'(told1), 32'(modelTold(1, destIdx1)));
        end
    end

    task automatic applyStimulus(
        input logic rst, input logic rec, input logic [1:0] num,
        input logic [4:0] ra0, input logic [4:0] rb0, input logic [4:0] d0, input logic [6:0] f0,
        input logic [4:0] ra1, input logic [4:0] rb1, input logic [4:0] d1, input logic [6:0] f1,
        input logic cv0, input logic [6:0] ct0, input logic cv1, input logic [6:0] ct1);
        reset = rst; robRecover = rec; dispatchNum = num;
        raIdx0 = ra0; rbIdx0 = rb0; destIdx0 = d0; flPr0 = f0;
        raIdx1 = ra1; rbIdx1 = rb1; destIdx1 = d1; flPr1 = f1;
        cdbValid0 = cv0; cdbTag0 = ct0; cdbValid1 = cv1; cdbTag1 = ct1;
    endtask

    task automatic expectSlot0(input string tag, input int raT, input int raR,
                               input int rbT, input int rbR, input int tOld);
        checkOutput({tag, " ra_tag0"}, 32'(raTag0), raT);
        checkOutput({tag, " ra_rdy0"}, 32'(raRdy0), raR);
        checkOutput({tag, " rb_tag0"}, 32'(rbTag0), rbT);
        checkOutput({tag, " rb_rdy0"}, 32'(rbRdy0), rbR);
        checkOutput({tag, " told0"},   32'(told0),  tOld);
    endtask

    task automatic expectSlot1(input string tag, input int raT, input int raR,
                               input int rbT, input int rbR, input int tOld);
        checkOutput({tag, " ra_tag1"}, 32'(raTag1), raT);
        checkOutput({tag, " ra_rdy1"}, 32'(raRdy1), raR);
        checkOutput({tag, " rb_tag1"}, 32'(rbTag1), rbT);
        checkOutput({tag, " rb_rdy1"}, 32'(rbRdy1), rbR);
        checkOutput({tag, " told1"},   32'(told1),  tOld);
    endtask

    task automatic toNegedge();
        @(negedge clock);
    endtask

    task automatic toNextCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rratFlat = '0;
        applyStimulus(0, 0, 1, 10, 11, 12, 90, 0, 0, 0, 0, 0, 0, 0, 0);
        checkEn = 1;
        $display("[TB] reset map lookup");
        toNegedge(); expectSlot0("reset", 10, 1, 11, 1, 12); expectSlot1("reset", 0, 0, 0, 0, 0);
        toNextCycle();

        applyStimulus(1, 0, 1, 3, 4, 5, 32, 0, 0, 0, 0, 0, 0, 0, 0);
        toNegedge(); expectSlot0("first", 3, 1, 4, 1, 5); expectSlot1("first", 0, 0, 0, 0, 0);
        toNextCycle();

        applyStimulus(1, 0, 1, 5, 5, 8, 33, 0, 0, 0, 0, 0, 0, 0, 0);
        toNegedge(); expectSlot0("renamed", 32, 0, 32, 0, 8);
        toNextCycle();

        applyStimulus(1, 0, 1, 5, 9, 9, 34, 0, 0, 0, 0, 1, 32, 0, 0);
        toNegedge(); expectSlot0("cdbbypass", 32, 1, 9, 1, 9);
        toNextCycle();

        applyStimulus(1, 0, 1, 8, 9, 8, 50, 0, 0, 0, 0, 1, 33, 0, 0);
        toNegedge(); expectSlot0("oldbcast", 33, 1, 34, 0, 33);
        toNextCycle();

        applyStimulus(1, 0, 2, 8, 9, 7, 40, 7, 8, 7, 41, 0, 0, 0, 0);
        toNegedge(); expectSlot0("samedest", 50, 0, 34, 0, 7); expectSlot1("samedest", 40, 0, 50, 0, 40);
        toNextCycle();

        applyStimulus(1, 0, 2, 7, 12, 1, 42, 1, 7, 2, 43, 1, 41, 0, 0);
        toNegedge(); expectSlot0("pair", 41, 1, 12, 1, 1); expectSlot1("pair", 42, 0, 41, 1, 2);
        toNextCycle();

        applyStimulus(1, 0, 3, 1, 2, 1, 60, 1, 2, 3, 61, 0, 0, 0, 0);
        toNegedge(); expectSlot0("num3", 0, 0, 0, 0, 0); expectSlot1("num3", 0, 0, 0, 0, 0);
        toNextCycle();

        applyStimulus(1, 0, 1, 1, 2, 1, 44, 0, 0, 0, 0, 0, 0, 0, 0);
        toNegedge(); expectSlot0("afternum3", 42, 0, 43, 0, 42);
        toNextCycle();

        for (int i = 0; i < 32; i++) rratFlat[i*7 +: 7] = 7'(i + 32);
        applyStimulus(1, 1, 2, 1, 7, 3, 70, 3, 5, 4, 71, 0, 0, 0, 0);
        toNegedge(); expectSlot0("recover", 44, 0, 41, 1, 3); expectSlot1("recover", 70, 0, 32, 1, 4);
        toNextCycle();

        applyStimulus(1, 0, 2, 3, 31, 10, 64, 0, 4, 11, 65, 0, 0, 0, 0);
        toNegedge(); expectSlot0("postrecover", 35, 1, 63, 1, 42); expectSlot1("postrecover", 32, 1, 36, 1, 43);
        toNextCycle();

        applyStimulus(0, 0, 1, 10, 11, 3, 80, 0, 0, 0, 0, 0, 0, 0, 0);
        toNegedge(); expectSlot0("midreset", 10, 1, 11, 1, 3);
        toNextCycle();

        applyStimulus(1, 0, 1, 3, 10, 20, 81, 0, 0, 0, 0, 0, 0, 0, 0);
        toNegedge(); expectSlot0("afterreset", 3, 1, 10, 1, 20);
        toNextCycle();

        $display("[TB] mixed traffic against model");
        for (int s = 0; s < 40; s++) begin
            applyStimulus(1, ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                          5'($urandom), 5'($urandom), 5'($urandom_range(0, 7)), 7'($urandom_range(0, 95)),
                          5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom_range(0, 7)), 7'($urandom_range(0, 95)),
                          1'($urandom), 7'($urandom_range(0, 95)), 1'($urandom), 7'($urandom_range(0, 95)));
            toNextCycle();
        end

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        toNegedge();
        checkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rename_mt.md
RENAME_MT -- requirements
Module: rename_mt

Interface
REQ-001 SHALL have parameter NUM_AR, default 32, number of architectural registers.
REQ-002 SHALL have parameter PR_W, default 7, physical tag width; legal tags are 0..95.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port id_dispatch_num, input, 2, number of instructions renamed this cycle (0..2); 3 is treated as 0.
REQ-006 SHALL have ports id_dest_idx0/id_dest_idx1, input, 5 each, destination arch regs of slot 0 and slot 1.
REQ-007 SHALL have ports id_ra_idx0/1 and id_rb_idx0/1, input, 5 each, source arch regs per slot.
REQ-008 SHALL have ports fl_pr0/fl_pr1, input, 7 each, new tags from the free list for slot 0 and slot 1.
REQ-009 SHALL have ports cdb_valid0/1, input, 1 each, and cdb_tag0/1, input, 7 each, the completion broadcasts.
REQ-010 SHALL have ports rob_recover, input, 1, and rrat_map_flat, input, 224, retirement map, entry i at bits [7i+6:7i].
REQ-011 SHALL have ports mt_ra_tag0/1, mt_rb_tag0/1, output, 7 each, renamed source tags.
REQ-012 SHALL have ports mt_ra_rdy0/1, mt_rb_rdy0/1, output, 1 each, source-ready flags.
REQ-013 SHALL have ports mt_told0/1, output, 7 each, previous dest mapping, forwarded to the ROB for later freeing.

Function
REQ-014 SHALL hold a 32-entry map (7-bit tag plus ready bit per arch reg).
REQ-015 SHALL produce all outputs combinationally in the same cycle as the dispatch inputs (zero latency).
REQ-016 Slot k (k < id_dispatch_num) SHALL output map[src].tag and map[src].rdy for each source, and map[dest].tag on mt_toldk.
REQ-017 Outputs of slots with k >= id_dispatch_num SHALL be 0 (tags, rdy, told).
REQ-018 Intra-bundle: if num=2 and an id_ra_idx1/id_rb_idx1 source equals id_dest_idx0, that source SHALL output fl_pr0 with rdy=0.
REQ-019 Intra-bundle: if num=2 and id_dest_idx1 equals id_dest_idx0, mt_told1 SHALL be fl_pr0.
REQ-020 CDB bypass: a source whose looked-up tag (not an intra-bundle fl_pr0) equals a valid cdb_tag SHALL output rdy=1.
REQ-021 On a rising edge, for each dispatched slot the map SHALL set map[dest] to {fl_prk, rdy=0}; slot 1 wins on equal dests.
REQ-022 On a rising edge, each entry whose current tag equals a valid cdb_tag SHALL set rdy=1.
REQ-023 If an entry is renamed and its old tag is broadcast in the same cycle, the new mapping SHALL be written with rdy=0.
REQ-024 If a tag dispatched this cycle (fl_prk) is broadcast in the same cycle, the new mapping SHALL be written with rdy=0; this is illegal upstream and not checked.
REQ-025 When rob_recover=1, on the rising edge the map SHALL load rrat_map_flat with all rdy=1, ignoring dispatch and CDB that cycle.
REQ-026 While rob_recover=1, outputs SHALL still follow REQ-016..020; consumers discard them.

Reset
REQ-027 While reset=0, the map SHALL immediately (asynchronously) become map[i] = {tag i, rdy=1} for i=0..31.
REQ-028 After reset, tags 32..95 SHALL be owned by the free list and never be present in the map until dispatched.
REQ-029 Reset asserted mid-dispatch SHALL discard that cycle's writes; outputs are combinational and follow the reset map.

Verification
REQ-030 Reset, then num=1, ra0=3, rb0=4, dest0=5, fl_pr0=32 -> ra_tag0=3, rdy=1, rb_tag0=4, rdy=1, told0=5; next cycle map[5]={32,0}.
REQ-031 num=2, dest0=7 fl_pr0=40, ra1=7, dest1=7 fl_pr1=41 -> ra_tag1=40 rdy1=0, told1=40; after edge map[7]={41,0}.
REQ-032 map[5]={32,0}, cdb_valid0=1 tag 32, lookup ra0=5 same cycle -> ra_rdy0=1; after edge map[5].rdy=1.
REQ-033 map[5]={32,0}, dest0=5 fl_pr0=50 with cdb tag 32 same cycle -> after edge map[5]={50,0}.
REQ-034 After several renames, rob_recover=1 with rrat_map_flat entry i = i+32 -> after edge every lookup of arch i gives tag i+32, rdy=1; concurrent dispatch has no effect.
REQ-035 id_dispatch_num=3 with valid-looking fields -> all outputs 0 and map unchanged after edge.
